cheri_bg_mem_arb: RTL
=====================

Name: cheri_bg_mem_arb

Overview:
Arbiter sharing one background data-memory port between the TBRE (revocation walker) and STKZ (stack zeroiser) engines.
- Sits between the two engines and the LSU-side background port of the core.
- Yields to CPU LSU traffic.
- Applies round-robin with a burst cap so neither engine starves.
- Routes read responses back to the issuing engine through an in-order owner FIFO.

Parameters:
MAX_OUTSTANDING, 2, max granted-but-unanswered transactions (owner FIFO depth, 1..4)
MAX_BURST, 4, max consecutive grants to one engine while the other is requesting (1..15)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-high (asserted when 1)
cpu_lsu_busy_i  in  1  CPU LSU transaction in flight; blocks new background requests
tbre_req_i  in  1  TBRE request; held stable until tbre_gnt_o
tbre_we_i  in  1  TBRE write enable
tbre_addr_i  in  32  TBRE word address (8-byte aligned for cap access)
tbre_wdata_i  in  33  TBRE write data, bit 32 = tag
tbre_gnt_o  out  1  TBRE address phase accepted
tbre_rvalid_o  out  1  TBRE response valid
stkz_req_i  in  1  STKZ request
stkz_we_i  in  1  STKZ write enable
stkz_addr_i  in  32  STKZ address
stkz_wdata_i  in  33  STKZ write data
stkz_gnt_o  out  1  STKZ grant
stkz_rvalid_o  out  1  STKZ response valid
bg_rdata_o  out  33  response data, shared by both engines
bg_err_o  out  1  response error, qualified by either rvalid
mem_req_o  out  1  request to memory port
mem_we_o  out  1  write enable
mem_addr_o  out  32  address
mem_wdata_o  out  33  write data
mem_gnt_i  in  1  memory grant
mem_rvalid_i  in  1  memory response valid
mem_rdata_i  in  33  memory response data
mem_err_i  in  1  memory response error
arb_idle_o  out  1  no request pending and owner FIFO empty

Behaviour:
- Reset values: all outputs 0, except arb_idle_o=1. State IDLE, last_owner=STKZ (TBRE wins the first tie), burst_cnt=0, FIFO empty.
- FSM states: IDLE, LOCK_T, LOCK_S.
- IDLE:
  - Selects an owner if any engine requests, cpu_lsu_busy_i=0 and FIFO not full.
  - Sole requester wins.
  - If both request, the non-last_owner wins, unless last_owner has burst_cnt<MAX_BURST, in which case last_owner keeps the port.
  - Moves to LOCK_T or LOCK_S and drives mem_req_o in the same cycle (combinational path; zero added latency).
- LOCK_x:
  - mem_req_o=1 with the owner's we/addr/wdata muxed through.
  - Owner held until mem_gnt_i; no switching and no abort, even if cpu_lsu_busy_i rises.
  - x_gnt_o = mem_gnt_i for the owner only.
  - On gnt: push owner id to FIFO and update last_owner.
  - burst_cnt: increments (saturating at MAX_BURST) if owner == previous owner, else set to 1.
  - On gnt, the next owner is re-evaluated the same cycle using the IDLE rules, so back-to-back grants are allowed; otherwise the FSM returns to IDLE.
- burst_cnt clears to 0 in any cycle where the other engine is not requesting.
- Responses:
  - mem_rvalid_i pops the FIFO head and asserts the matching x_rvalid_o in the same cycle.
  - bg_rdata_o=mem_rdata_i and bg_err_o=mem_err_i.
- FIFO boundaries:
  - Simultaneous push and pop is legal at any occupancy, including full (no new request while full, but a gnt for an already-presented request can coincide with a pop).
  - mem_rvalid_i with an empty FIFO is a protocol error: ignored, no rvalid issued; flagged by assertion.
- Engine dropping req before gnt: protocol violation, covered by assertion; the arbiter keeps presenting the latched owner's inputs as live.
- Reset mid-transaction: everything returns to reset values immediately; outstanding responses arriving after reset are dropped.

Optional Feature:
CHERI_BG_ARB_STATS_EN
- Defined:
  - Adds outputs tbre_gnt_cnt_o[15:0], stkz_gnt_cnt_o[15:0] and stall_cnt_o[15:0], all saturating, reset to 0.
  - stall_cnt_o counts cycles where an engine requests while cpu_lsu_busy_i=1.
- Undefined: the ports and counters are absent. Arbitration is identical either way.

Test Plan:
- TBRE-only read, mem_gnt_i same cycle, rvalid 2 cycles later -> tbre_gnt_o same cycle as tbre_req_i; tbre_rvalid_o=1 with bg_rdata_o=33'h1_8002_0010; stkz_rvalid_o stays 0.
- Both engines request continuously, MAX_BURST=4, gnt every cycle -> grant pattern T,T,T,T,S,S,S,S,T... (TBRE first after reset).
- cpu_lsu_busy_i=1 while both request -> mem_req_o=0 until busy drops; then mem_req_o rises the same cycle. Busy rising during LOCK_S with gnt delayed 3 cycles -> request held, STKZ granted.
- MAX_OUTSTANDING=2: two grants, no rvalid -> third request blocked (mem_req_o=0); rvalid and a new gnt in the same cycle -> FIFO count stays 2, responses delivered in order T then S.
- Assert rst_n=1 with FIFO holding 1 entry, then deassert -> arb_idle_o=1; a stray mem_rvalid_i produces no x_rvalid_o.
- With CHERI_BG_ARB_STATS_EN: 5 TBRE grants and 3 STKZ grants -> tbre_gnt_cnt_o=5, stkz_gnt_cnt_o=3.

Source files
------------

// File: rtl/cheri_bg_mem_arb.sv
// Arbiter sharing one background memory port between the TBRE and STKZ engines.
// Optional grant/stall counters are enabled by defining CHERI_BG_ARB_STATS_EN.
module cheri_bg_mem_arb #(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned MAX_BURST       = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_lsu_busy_i,
  input  logic        tbre_req_i,
  input  logic        tbre_we_i,
  input  logic [31:0] tbre_addr_i,
  input  logic [32:0] tbre_wdata_i,
  output logic        tbre_gnt_o,
  output logic        tbre_rvalid_o,
  input  logic        stkz_req_i,
  input  logic        stkz_we_i,
  input  logic [31:0] stkz_addr_i,
  input  logic [32:0] stkz_wdata_i,
  output logic        stkz_gnt_o,
  output logic        stkz_rvalid_o,
  output logic [32:0] bg_rdata_o,
  output logic        bg_err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [32:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [32:0] mem_rdata_i,
  input  logic        mem_err_i,
  output logic        arb_idle_o
`ifdef CHERI_BG_ARB_STATS_EN
  ,
  output logic [15:0] tbre_gnt_cnt_o,
  output logic [15:0] stkz_gnt_cnt_o,
  output logic [15:0] stall_cnt_o
`endif
);

  // Handshake: a transaction is accepted in the cycle where mem_req_o && mem_gnt_i;
  // once presented, the request and its payload stay fixed until that cycle.
  // Responses return in grant order, one per mem_rvalid_i.

  typedef enum logic [1:0] {IDLE, LOCK_T, LOCK_S} state_e;

  localparam logic       OWN_T       = 1'b0;
  localparam logic       OWN_S       = 1'b1;
  localparam logic [3:0] MAX_BURST_L = 4'(MAX_BURST);
  localparam logic [2:0] MAX_OUT_L   = 3'(MAX_OUTSTANDING);

  state_e                     state_q, state_d;
  logic                       last_owner_q, last_owner_d;
  logic [3:0]                 burst_q, burst_d;
  logic [2:0]                 cnt_q, cnt_d;
  logic [MAX_OUTSTANDING-1:0] owner_q, owner_d;

  logic       pick, cur, active, push, pop, room, other_req;
  logic [2:0] wr_idx;

  assign pop  = mem_rvalid_i && (cnt_q != 3'd0);
  // A response leaving this cycle frees the slot the new grant would take.
  assign room = (cnt_q != MAX_OUT_L) || pop;

  always_comb begin
    pick = OWN_T;
    if (tbre_req_i && stkz_req_i) begin
      // A burst in progress (non-zero count below the cap) keeps the port.
      pick = ((burst_q != 4'd0) && (burst_q < MAX_BURST_L)) ? last_owner_q : ~last_owner_q;
    end else if (stkz_req_i) begin
      pick = OWN_S;
    end
  end

  always_comb begin
    active = 1'b0;
    cur    = pick;
    case (state_q)
      LOCK_T: begin
        active = 1'b1;
        cur    = OWN_T;
      end
      LOCK_S: begin
        active = 1'b1;
        cur    = OWN_S;
      end
      default: begin
        active = (tbre_req_i || stkz_req_i) && !cpu_lsu_busy_i && room;
        cur    = pick;
      end
    endcase
  end

  assign push = active && mem_gnt_i;

  always_comb begin
    mem_req_o   = active;
    mem_we_o    = 1'b0;
    mem_addr_o  = 32'd0;
    mem_wdata_o = 33'd0;
    if (active) begin
      mem_we_o    = (cur == OWN_S) ? stkz_we_i    : tbre_we_i;
      mem_addr_o  = (cur == OWN_S) ? stkz_addr_i  : tbre_addr_i;
      mem_wdata_o = (cur == OWN_S) ? stkz_wdata_i : tbre_wdata_i;
    end
  end

  assign tbre_gnt_o    = push && (cur == OWN_T);
  assign stkz_gnt_o    = push && (cur == OWN_S);
  assign tbre_rvalid_o = pop && (owner_q[0] == OWN_T);
  assign stkz_rvalid_o = pop && (owner_q[0] == OWN_S);
  assign bg_rdata_o    = mem_rdata_i;
  assign bg_err_o      = mem_err_i;
  assign arb_idle_o    = (state_q == IDLE) && !tbre_req_i && !stkz_req_i && (cnt_q == 3'd0);

  // After a grant the FSM drops to IDLE, whose combinational pick re-arbitrates
  // with fresh requests in the following cycle without a bubble.
  always_comb begin
    state_d      = IDLE;
    last_owner_d = last_owner_q;
    burst_d      = burst_q;
    if (push) begin
      last_owner_d = cur;
      if (cur == last_owner_q) begin
        burst_d = (burst_q == MAX_BURST_L) ? burst_q : burst_q + 4'd1;
      end else begin
        burst_d = 4'd1;
      end
    end else if (active) begin
      state_d = (cur == OWN_S) ? LOCK_S : LOCK_T;
    end
    other_req = (last_owner_d == OWN_S) ? tbre_req_i : stkz_req_i;
    if (!other_req) begin
      burst_d = 4'd0;
    end
  end

  always_comb begin
    cnt_d   = cnt_q;
    wr_idx  = pop ? cnt_q - 3'd1 : cnt_q;
    owner_d = pop ? (owner_q >> 1) : owner_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 3'd1;
      2'b01:   cnt_d = cnt_q - 3'd1;
      default: cnt_d = cnt_q;
    endcase
    if (push) begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        if (3'(i) == wr_idx) owner_d[i] = cur;
      end
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q      <= IDLE;
      last_owner_q <= OWN_S;
      burst_q      <= 4'd0;
      cnt_q        <= 3'd0;
      owner_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      burst_q      <= burst_d;
      cnt_q        <= cnt_d;
      owner_q      <= owner_d;
    end
  end

`ifdef CHERI_BG_ARB_STATS_EN
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      tbre_gnt_cnt_o <= 16'd0;
      stkz_gnt_cnt_o <= 16'd0;
      stall_cnt_o    <= 16'd0;
    end else begin
      if (tbre_gnt_o && (tbre_gnt_cnt_o != 16'hFFFF)) tbre_gnt_cnt_o <= tbre_gnt_cnt_o + 16'd1;
      if (stkz_gnt_o && (stkz_gnt_cnt_o != 16'hFFFF)) stkz_gnt_cnt_o <= stkz_gnt_cnt_o + 16'd1;
      if ((tbre_req_i || stkz_req_i) && cpu_lsu_busy_i && (stall_cnt_o != 16'hFFFF))
        stall_cnt_o <= stall_cnt_o + 16'd1;
    end
  end
`endif

`ifndef SYNTHESIS
  // Responses still in flight from before a reset are legal until new traffic is granted.
  logic seen_gnt_q;
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) seen_gnt_q <= 1'b0;
    else if (push) seen_gnt_q <= 1'b1;
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      if (state_q == LOCK_T) assert (tbre_req_i) else $error("tbre_req_i dropped before grant");
      if (state_q == LOCK_S) assert (stkz_req_i) else $error("stkz_req_i dropped before grant");
      if (seen_gnt_q) assert (!(mem_rvalid_i && cnt_q == 3'd0)) else $error("mem_rvalid_i with no outstanding grant");
    end
  end
`endif

endmodule
